// File: rtl/fls_input_cond.sv
// Conditions a bouncing push-button and a switch bank for the fls generator:
// 2-FF synchronisers, debounce FSM, one enable pulse plus switch snapshot per press.
module fls_input_cond #(
  parameter int W       = 7,
  parameter int CNT_MAX = 1_000_000,
  parameter int CW      = $clog2(CNT_MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btn,
  input  logic [W-1:0] sw,
  output logic         en_out,
  output logic [W-1:0] d_out,
  output logic         btn_db,
  output logic [7:0]   press_cnt
);

  localparam logic [1:0] IDLE_LOW  = 2'd0;
  localparam logic [1:0] WAIT_HIGH = 2'd1;
  localparam logic [1:0] IDLE_HIGH = 2'd2;
  localparam logic [1:0] WAIT_LOW  = 2'd3;

  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  logic         btn_s1_q, btn_s2_q;
  logic [W-1:0] sw_s1_q, sw_s2_q;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          en_q, en_d;
  logic [W-1:0]  d_q, d_d;
  logic          db_q, db_d;
  logic [7:0]    press_q, press_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_s1_q <= 1'b0;
      btn_s2_q <= 1'b0;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
    end else begin
      btn_s1_q <= btn;
      btn_s2_q <= btn_s1_q;
      sw_s1_q  <= sw;
      sw_s2_q  <= sw_s1_q;
    end
  end

  // Any level change seen in a WAIT state restarts qualification from zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_d    = 1'b0;
    d_d     = d_q;
    press_d = press_q;
    case (state_q)
      IDLE_LOW: begin
        if (btn_s2_q) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!btn_s2_q) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HIGH;
          en_d    = 1'b1;
          d_d     = sw_s2_q;
          press_d = press_q + 8'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      IDLE_HIGH: begin
        if (!btn_s2_q) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (btn_s2_q) begin
          state_d = IDLE_HIGH;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE_LOW;
    endcase
    // Debounced level follows the next state so it moves with the state register.
    db_d = (state_d == IDLE_HIGH) || (state_d == WAIT_LOW);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      d_q     <= '0;
      db_q    <= 1'b0;
      press_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      d_q     <= d_d;
      db_q    <= db_d;
      press_q <= press_d;
    end
  end

  assign en_out    = en_q;
  assign d_out     = d_q;
  assign btn_db    = db_q;
  assign press_cnt = press_q;

endmodule

// File: tb/tb_fls_input_cond.sv
// Directed bench for fls_input_cond with CNT_MAX=4: a per-cycle vector table
// for a clean press/release plus hand-written reset, bounce, glitch, snapshot and wrap sequences.
module tb_fls_input_cond;

  localparam int W = 7;

  logic         clk;
  logic         rst;
  logic         btn;
  logic [W-1:0] sw;
  logic         en_out;
  logic [W-1:0] d_out;
  logic         btn_db;
  logic [7:0]   press_cnt;

  int checks = 0;
  int errors = 0;
  logic prev_en = 1'b0;

  fls_input_cond #(.W(W), .CNT_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .sw        (sw),
    .en_out    (en_out),
    .d_out     (d_out),
    .btn_db    (btn_db),
    .press_cnt (press_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic         btn;
    logic [W-1:0] sw;
    logic         en;
    logic [W-1:0] d;
    logic         db;
    logic [7:0]   cnt;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // One clock edge, then sample outputs 1 time unit later; flags multi-cycle pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    if (en_out) chk("en_single_cycle", int'(prev_en), 0);
    prev_en = en_out;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en"}, int'(en_out), 0);
    chk({tag, "_d"}, int'(d_out), 0);
    chk({tag, "_db"}, int'(btn_db), 0);
    chk({tag, "_cnt"}, int'(press_cnt), 0);
  endtask

  int n_pulse;
  int first_pulse;
  int low_db;

  initial begin
    // Clean press and release from IDLE_LOW; press_cnt starts at 1, d_out at 55.
    vecs[0]  = '{1'b1, 7'h02, 1'b0, 7'h55, 1'b0, 8'd1};
    vecs[1]  = '{1'b1, 7'h02, 1'b0, 7'h55, 1'b0, 8'd1};
    vecs[2]  = '{1'b1, 7'h02, 1'b0, 7'h55, 1'b0, 8'd1};
    vecs[3]  = '{1'b1, 7'h02, 1'b0, 7'h55, 1'b0, 8'd1};
    vecs[4]  = '{1'b1, 7'h02, 1'b0, 7'h55, 1'b0, 8'd1};
    vecs[5]  = '{1'b1, 7'h02, 1'b0, 7'h55, 1'b0, 8'd1};
    vecs[6]  = '{1'b1, 7'h02, 1'b1, 7'h02, 1'b1, 8'd2};
    vecs[7]  = '{1'b1, 7'h02, 1'b0, 7'h02, 1'b1, 8'd2};
    vecs[8]  = '{1'b0, 7'h02, 1'b0, 7'h02, 1'b1, 8'd2};
    vecs[9]  = '{1'b0, 7'h02, 1'b0, 7'h02, 1'b1, 8'd2};
    vecs[10] = '{1'b0, 7'h02, 1'b0, 7'h02, 1'b1, 8'd2};
    vecs[11] = '{1'b0, 7'h02, 1'b0, 7'h02, 1'b1, 8'd2};
    vecs[12] = '{1'b0, 7'h02, 1'b0, 7'h02, 1'b1, 8'd2};
    vecs[13] = '{1'b0, 7'h02, 1'b0, 7'h02, 1'b1, 8'd2};
    vecs[14] = '{1'b0, 7'h02, 1'b0, 7'h02, 1'b0, 8'd2};

    // Reset held with button pressed and switches set.
    rst = 1'b0;
    btn = 1'b1;
    sw  = 7'h55;
    repeat (3) tick();
    chk_all_zero("reset_hold");
    $display("reset hold: en=%0d d=%0h db=%0d cnt=%0d", en_out, d_out, btn_db, press_cnt);

    // Release, reach WAIT_HIGH, then reset asynchronously mid-count.
    rst = 1'b1;
    repeat (4) tick();
    chk("midwait_db", int'(btn_db), 0);
    chk("midwait_en", int'(en_out), 0);
    rst = 1'b0;
    #1;
    chk_all_zero("midwait_reset");
    repeat (2) tick();
    rst = 1'b1;
    n_pulse = 0;
    first_pulse = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (en_out) begin
        n_pulse++;
        if (first_pulse < 0) first_pulse = i;
      end
    end
    chk("rst_release_pulses", n_pulse, 1);
    chk("rst_release_pulse_edge", first_pulse, 7);
    chk("rst_release_cnt", int'(press_cnt), 1);
    chk("rst_release_d", int'(d_out), 'h55);
    chk("rst_release_db", int'(btn_db), 1);
    $display("press after reset: pulses=%0d edge=%0d d=%0h cnt=%0d", n_pulse, first_pulse, d_out, press_cnt);
    btn = 1'b0;
    repeat (10) tick();
    chk("rst_release_db_low", int'(btn_db), 0);

    // Table-driven clean press and release.
    for (int i = 0; i < 15; i++) begin
      btn = vecs[i].btn;
      sw  = vecs[i].sw;
      tick();
      chk($sformatf("vec%0d_en", i), int'(en_out), int'(vecs[i].en));
      chk($sformatf("vec%0d_d", i), int'(d_out), int'(vecs[i].d));
      chk($sformatf("vec%0d_db", i), int'(btn_db), int'(vecs[i].db));
      chk($sformatf("vec%0d_cnt", i), int'(press_cnt), int'(vecs[i].cnt));
      $display("vec %0d: btn=%0d en=%0d d=%0h db=%0d cnt=%0d", i, btn, en_out, d_out, btn_db, press_cnt);
    end

    // Bounce 1,1,0,0,1,1,0,0 then hold high: one pulse 6 edges after index 8.
    n_pulse = 0;
    first_pulse = -1;
    for (int i = 0; i < 24; i++) begin
      if (i < 8) btn = ((i % 4) < 2);
      else btn = 1'b1;
      tick();
      if (en_out) begin
        n_pulse++;
        if (first_pulse < 0) first_pulse = i;
      end
    end
    chk("bounce_pulses", n_pulse, 1);
    chk("bounce_pulse_edge", first_pulse, 14);
    chk("bounce_cnt", int'(press_cnt), 3);
    $display("bounce: pulses=%0d edge=%0d cnt=%0d", n_pulse, first_pulse, press_cnt);

    // Long hold with a 2-cycle low glitch: no new pulse, btn_db never drops.
    n_pulse = 0;
    low_db = 0;
    for (int i = 0; i < 72; i++) begin
      btn = !(i >= 50 && i < 52);
      tick();
      if (en_out) n_pulse++;
      if (!btn_db) low_db++;
    end
    chk("glitch_pulses", n_pulse, 0);
    chk("glitch_db_low_cycles", low_db, 0);
    chk("glitch_cnt", int'(press_cnt), 3);
    $display("hold glitch: pulses=%0d db_low=%0d cnt=%0d", n_pulse, low_db, press_cnt);
    btn = 1'b0;
    repeat (10) tick();
    chk("glitch_release_db", int'(btn_db), 0);

    // Snapshot: d_out only follows switches at an accepted press.
    sw  = 7'h03;
    btn = 1'b1;
    repeat (10) tick();
    chk("snap1_d", int'(d_out), 'h03);
    chk("snap1_cnt", int'(press_cnt), 4);
    btn = 1'b0;
    sw  = 7'h04;
    repeat (12) tick();
    chk("snap_hold_d", int'(d_out), 'h03);
    btn = 1'b1;
    repeat (10) tick();
    chk("snap2_d", int'(d_out), 'h04);
    chk("snap2_cnt", int'(press_cnt), 5);
    $display("snapshot: d=%0h cnt=%0d", d_out, press_cnt);
    btn = 1'b0;
    repeat (10) tick();

    // Wrap: 256 presses from a fresh reset.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("wrap_start_cnt", int'(press_cnt), 0);
    n_pulse = 0;
    for (int p = 0; p < 256; p++) begin
      btn = 1'b1;
      repeat (8) begin
        tick();
        if (en_out) n_pulse++;
      end
      btn = 1'b0;
      repeat (8) begin
        tick();
        if (en_out) n_pulse++;
      end
      if (p == 254) chk("wrap_cnt_255", int'(press_cnt), 255);
      $display("wrap press %0d: press_cnt=%0d pulses=%0d", p, press_cnt, n_pulse);
    end
    chk("wrap_pulses", n_pulse, 256);
    chk("wrap_end_cnt", int'(press_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
